// File: rtl/mas_rr_arbiter.sv
// mas_rr_arbiter: N-way valid/ready arbiter with round-robin or fixed
// priority, burst locking with a forced release after MAX_BURST beats,
// and a single registered output stage.
module mas_rr_arbiter #(
  parameter int unsigned N_INPUTS   = 8,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MODE       = 0,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned SRC_W      = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS-1:0]            in_valid,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]            in_last,
  output logic [N_INPUTS-1:0]            in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_last,
  output logic [SRC_W-1:0]               out_src,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SRC_W-1:0]      r_owner;
  logic [SRC_W-1:0]      w_owner_nxt;
  logic [SRC_W-1:0]      r_rr_ptr;
  logic [SRC_W-1:0]      w_rr_ptr_nxt;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [CNT_W-1:0]      w_beat_cnt_nxt;
  logic [SRC_W-1:0]      w_win;
  logic                  w_has_win;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_force;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_win_data;
  int unsigned           w_scan;

  assign w_load     = !out_valid || out_ready;
  assign w_accept   = w_load && w_has_win;
  assign w_force    = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_last     = in_last[w_win] || w_force;
  assign w_win_data = in_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
  assign busy       = (r_state == S_LOCKED) || out_valid;

  // Winner selection: owner while locked, otherwise rotating or lowest-index scan
  always_comb begin
    w_win     = '0;
    w_has_win = 1'b0;
    w_scan    = 0;
    if (r_state == S_LOCKED) begin
      w_win     = r_owner;
      w_has_win = in_valid[r_owner];
    end else if (MODE == 1) begin
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        if (!w_has_win && in_valid[SRC_W'(i)]) begin
          w_has_win = 1'b1;
          w_win     = SRC_W'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        w_scan = (32'(r_rr_ptr) + i) % N_INPUTS;
        if (!w_has_win && in_valid[SRC_W'(w_scan)]) begin
          w_has_win = 1'b1;
          w_win     = SRC_W'(w_scan);
        end
      end
    end
  end

  // One-hot ready to the winner, forced low while reset is asserted
  always_comb begin
    in_ready = '0;
    if (!rst && w_accept) begin
      in_ready[w_win] = 1'b1;
    end
  end

  // Next-state: lock on a non-final beat, release and rotate on a final one
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    if (w_accept) begin
      if (w_last) begin
        w_state_nxt    = S_IDLE;
        w_beat_cnt_nxt = '0;
        if (MODE == 0) begin
          w_rr_ptr_nxt = (w_win == SRC_W'(N_INPUTS - 1)) ? '0 : w_win + 1'b1;
        end
      end else begin
        w_state_nxt    = S_LOCKED;
        w_owner_nxt    = w_win;
        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Output register: load on accept, clear valid on drain, hold payload otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_data  <= w_win_data;
      out_last  <= w_last;
      out_src   <= w_win;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mas_rr_arbiter.md
# mas_rr_arbiter

Parametrised N-way memory-access arbiter for the memory access servicer path. It replaces the per-node two-input conflict flop with a single arbitration stage: round-robin or fixed priority, valid/ready handshakes on every port, multi-beat burst locking with a starvation cap, and one registered output stage. It sits between the requesting units and the memory port and presents one request stream downstream.

## Interface
- `N_INPUTS`, default 8: number of requesters, 2..32.
- `DATA_WIDTH`, default 128: request payload width (address plus command).
- `MODE`, default 0: 0 selects round-robin; 1 selects fixed priority, where the lowest index wins.
- `MAX_BURST`, default 16: maximum beats per grant before a forced release, 1..256.
- `SRC_W`, derived as `$clog2(N_INPUTS)`: width of the source index.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in `N_INPUTS`: per-requester valid.
- `in_data` in `N_INPUTS*DATA_WIDTH`: flattened payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_last` in `N_INPUTS`: marks the final beat of a burst.
- `in_ready` out `N_INPUTS`: per-requester accept, one-hot or zero.
- `out_valid` out 1: output register holds a beat.
- `out_data` out `DATA_WIDTH`: registered payload.
- `out_last` out 1: final beat of the burst, either natural or forced.
- `out_src` out `SRC_W`: index of the requester that sourced the beat.
- `out_ready` in 1: downstream accept.
- `busy` out 1: high when a grant is locked or `out_valid` is high.

## Operation
- **Output load enable:** `load = !out_valid || out_ready`.
- **State machine:** two states.
  - IDLE: no grant is held.
  - LOCKED: `owner` holds the grant.
- **Priority pointer:** `rr_ptr`, `SRC_W` bits, wraps modulo `N_INPUTS`.
- **Winner selection in IDLE:**
  - MODE 0: the first asserted `in_valid` scanning upward from `rr_ptr` and wrapping.
  - MODE 1: the lowest asserted index.
  - No valid input means no winner.
- **Winner selection in LOCKED:** the winner is `owner` only. All other `in_ready` bits stay 0 even if their `in_valid` is high.
- **Ready:** `in_ready[w] = load && in_valid[w]`, where w is the winner. `in_ready` is combinational. Exactly one bit or none is asserted.
- **Beat accept:** `in_valid[w] && in_ready[w]`. On accept, the output register loads:
  - `out_data` from payload w;
  - `out_src` = w;
  - `out_valid` = 1;
  - `out_last` = `in_last[w] || force`, where `force = (beat_cnt == MAX_BURST-1)`.
- **Beat counter:** `beat_cnt` is cleared on entering IDLE and increments on every accepted beat while the grant is held.
- **Accept with `out_last` = 0:** state goes to LOCKED, `owner` = w.
- **Accept with `out_last` = 1:** state goes to IDLE.
  - MODE 0: `rr_ptr` = (w+1) mod `N_INPUTS`.
  - MODE 1: `rr_ptr` is unchanged.
- **Output drain:** when `out_ready && out_valid` and no new accept occurs in the same cycle, `out_valid` goes to 0. `out_data`, `out_src` and `out_last` hold their last values.
- **Owner drops valid while LOCKED:** the grant is held. No beat is issued, and other requesters wait. A requester must not abandon a burst.
- **Forced release:** the requester may continue asserting valid. It re-arbitrates in IDLE like any other requester; in MODE 0 it now has lowest priority.
- **`MAX_BURST` = 1:** every beat is forced last, so arbitration happens on every beat.
- **Single requester:** it wins every cycle. Throughput is one beat per cycle while `out_ready` is high.

## Timing
- **Latency:** 1 cycle. A beat accepted at edge k is visible on `out_*` after edge k.
- **Throughput:** one beat per cycle when `out_ready` is held high, including back-to-back transfers across different owners.
- **Backpressure:** with `out_valid` = 1 and `out_ready` = 0, all `in_ready` bits are 0 and `out_*` is stable.
- **Arbitration:** same-cycle. No idle bubble between bursts.
- **Reset values:**

  | Signal | Value |
  |---|---|
  | `out_valid` | 0 |
  | `out_data` | 0 |
  | `out_last` | 0 |
  | `out_src` | 0 |
  | `busy` | 0 |
  | state | IDLE |
  | `owner` | 0 |
  | `rr_ptr` | 0 |
  | `beat_cnt` | 0 |

- **`in_ready` during reset:** combinationally 0 while `rst` is high.
- **Reset mid-burst:** the in-flight output beat is dropped, the lock is cleared, and the first cycle after deassertion arbitrates from index 0.

## Test plan
1. **Reset and single requester.** Reset, then hold `in_valid`[3]=1 and `in_last`[3]=1 with `out_ready`=1 for 4 cycles. Expect 4 consecutive beats with `out_src`=3 and `out_last`=1, first beat one cycle after the first accept. `rr_ptr` = 4.
2. **Round-robin fairness.** MODE 0, all 8 requesters valid with last=1, `out_ready`=1. Expect `out_src` sequence 0,1,2,...,7,0 with no idle cycles.
3. **Burst lock.** MODE 0. Requester 2 sends 3 beats, last on the 3rd, while requester 5 is valid throughout. Expect `out_src` = 2,2,2 then 5. `in_ready`[5] stays 0 during the lock.
4. **Forced release.** `MAX_BURST`=4. Requester 1 streams 10 beats without last, and requester 6 is valid. Expect beats 1,1,1,1 with the 4th `out_last`=1, then 6, then requester 1 resumes.
5. **Backpressure.** `out_ready`=0 for 5 cycles with the output full. Expect `out_data` stable, all `in_ready`=0, `busy`=1. On release, drain one beat per cycle.
6. **Fixed priority and mid-burst reset.**
   - MODE 1, requesters 0 and 4 valid: requester 0 always wins and 4 starves.
   - Assert `rst` mid-burst: `out_valid`=0 immediately, lock cleared.
